// File: rtl/hyperbus_cfg_init_pkg.sv
// Shared types for the HyperBus boot-time configurator: init FSM states (also used by
// debug/trace) and the default 32-bit register bus request/response structs.
package hyperbus_cfg_init_pkg;

    typedef enum logic [1:0] {
        DELAY  = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } hyper_init_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } hyper_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } hyper_reg_rsp_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hyperbus_cfg_init.sv
// Boot-time configurator in front of the HyperBus controller register port: replays a table of
// config writes (optionally verified by read-back), then becomes a transparent host pass-through.
module hyperbus_cfg_init
    import hyperbus_cfg_init_pkg::*;
#(
    parameter int unsigned NumEntries   = 4,
    parameter int unsigned RegAddrWidth = 32,
    parameter int unsigned RegDataWidth = 32,
    parameter logic [((NumEntries > 0) ? NumEntries : 1)-1:0][RegAddrWidth-1:0] InitAddr = '0,
    parameter logic [((NumEntries > 0) ? NumEntries : 1)-1:0][RegDataWidth-1:0] InitData = '0,
    parameter bit          VerifyEn     = 1'b1,
    parameter int unsigned MaxRetries   = 3,
    parameter int unsigned StartDelay   = 16,
    parameter type         reg_req_t    = hyper_reg_req_t,
    parameter type         reg_rsp_t    = hyper_reg_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  reg_req_t host_req_i,
    output reg_rsp_t host_rsp_o,
    output reg_req_t cfg_req_o,
    input  reg_rsp_t cfg_rsp_i,
    output logic     busy_o,
    output logic     init_done_o,
    output logic     init_error_o
);

    localparam int unsigned IdxWidth   = $clog2(max_u(NumEntries, 2));
    localparam int unsigned RetryWidth = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    localparam int unsigned DelayWidth = (StartDelay > 1) ? $clog2(StartDelay + 1) : 1;
    localparam int unsigned TabDepth   = 1 << IdxWidth;
    localparam int unsigned LastEntry  = (NumEntries > 0) ? NumEntries - 1 : 0;

    localparam logic [IdxWidth-1:0]   LastIdx   = IdxWidth'(LastEntry);
    localparam logic [RetryWidth-1:0] RetryMax  = RetryWidth'(MaxRetries);
    localparam logic [DelayWidth-1:0] DelayLast = DelayWidth'((StartDelay > 0) ? StartDelay - 1 : 0);

    if (StartDelay < 1) begin : g_chk_delay
        $error("hyperbus_cfg_init: StartDelay must be at least 1");
    end
    if ((RegDataWidth != 32) && (RegDataWidth != 64)) begin : g_chk_width
        $error("hyperbus_cfg_init: RegDataWidth must be 32 or 64");
    end

    // Table padded to a power of two so any idx value selects a defined entry.
    logic [RegAddrWidth-1:0] addr_tab [TabDepth];
    logic [RegDataWidth-1:0] data_tab [TabDepth];

    for (genvar gi = 0; gi < TabDepth; gi++) begin : g_tab
        if (gi < NumEntries) begin : g_used
            assign addr_tab[gi] = InitAddr[gi];
            assign data_tab[gi] = InitData[gi];
        end else begin : g_pad
            assign addr_tab[gi] = '0;
            assign data_tab[gi] = '0;
        end
    end

    hyper_init_state_e       state_reg, state_next;
    logic [IdxWidth-1:0]     idx_reg, idx_next;
    logic [RetryWidth-1:0]   retry_reg, retry_next;
    logic [DelayWidth-1:0]   delay_reg, delay_next;
    logic                    error_reg, error_next;
    reg_req_t                req_reg, req_next;

    logic [RegAddrWidth-1:0] entry_addr;
    logic [RegDataWidth-1:0] entry_data;
    logic                    accept;
    logic                    attempt_fail;
    logic                    entry_ok;

    function automatic reg_req_t make_req(input logic                    is_write,
                                          input logic [RegAddrWidth-1:0] a,
                                          input logic [RegDataWidth-1:0] d);
        reg_req_t r;
        r       = '0;
        r.valid = 1'b1;
        r.write = is_write;
        r.addr  = a;
        r.wdata = is_write ? d : '0;
        r.wstrb = is_write ? '1 : '0;
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= DELAY;
            idx_reg   <= '0;
            retry_reg <= '0;
            delay_reg <= '0;
            error_reg <= 1'b0;
            req_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            retry_reg <= retry_next;
            delay_reg <= delay_next;
            error_reg <= error_next;
            req_reg   <= req_next;
        end
    end

    assign entry_addr = addr_tab[idx_reg];
    assign entry_data = data_tab[idx_reg];
    assign accept     = req_reg.valid && cfg_rsp_i.ready;

    // A cycle with valid low inside WRITE/VERIFY is the mandatory gap between accesses;
    // the next request is loaded there so the outgoing request is always registered.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        retry_next   = retry_reg;
        delay_next   = delay_reg;
        error_next   = error_reg;
        req_next     = req_reg;
        attempt_fail = 1'b0;
        entry_ok     = 1'b0;

        unique case (state_reg)
            DELAY: begin
                if (delay_reg == DelayLast) begin
                    if (NumEntries == 0) begin
                        state_next = DONE;
                    end else begin
                        state_next = WRITE;
                        req_next   = make_req(1'b1, entry_addr, entry_data);
                    end
                end else begin
                    delay_next = delay_reg + DelayWidth'(1);
                end
            end
            WRITE: begin
                if (!req_reg.valid) begin
                    req_next = make_req(1'b1, entry_addr, entry_data);
                end else if (accept) begin
                    req_next = '0;
                    if (cfg_rsp_i.error) begin
                        attempt_fail = 1'b1;
                    end else if (VerifyEn) begin
                        state_next = VERIFY;
                    end else begin
                        entry_ok = 1'b1;
                    end
                end
            end
            VERIFY: begin
                if (!req_reg.valid) begin
                    req_next = make_req(1'b0, entry_addr, entry_data);
                end else if (accept) begin
                    req_next = '0;
                    if (cfg_rsp_i.error || (cfg_rsp_i.rdata != entry_data)) begin
                        attempt_fail = 1'b1;
                    end else begin
                        entry_ok = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // An entry that runs out of retries is flagged and then skipped like a good one.
        if (entry_ok || (attempt_fail && (retry_reg == RetryMax))) begin
            retry_next = '0;
            if (attempt_fail) begin
                error_next = 1'b1;
            end
            if (idx_reg == LastIdx) begin
                state_next = DONE;
            end else begin
                idx_next   = idx_reg + IdxWidth'(1);
                state_next = WRITE;
            end
        end else if (attempt_fail) begin
            retry_next = retry_reg + RetryWidth'(1);
            state_next = WRITE;
        end
    end

    always_comb begin
        if (state_reg == DONE) begin
            cfg_req_o  = host_req_i;
            host_rsp_o = cfg_rsp_i;
        end else begin
            cfg_req_o  = req_reg;
            host_rsp_o = '0;
        end
    end

    assign busy_o       = (state_reg != DONE);
    assign init_done_o  = (state_reg == DONE);
    assign init_error_o = error_reg;

endmodule

// File: tb/tb_hyperbus_cfg_init.sv
// Directed bench for hyperbus_cfg_init: three instances (verify, no-verify, empty table) with
// slave models; accesses are checked in order against a scoreboard queue.
module tb_hyperbus_cfg_init;
    import hyperbus_cfg_init_pkg::*;

    localparam logic [2:0][31:0] TabAddr = {32'h0000_0008, 32'h0000_0004, 32'h0000_0000};
    localparam logic [2:0][31:0] TabData = {32'hC0DE_0002, 32'hA5A5_0001, 32'h1234_0000};
    localparam logic [31:0]      HostRdExp = ~32'h0000_0010;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } acc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst_v_n, rst_o_n;
    hyper_reg_req_t v_host_req, v_cfg_req, n_cfg_req, z_cfg_req, n_host_req, z_host_req;
    hyper_reg_rsp_t v_host_rsp, v_cfg_rsp, n_cfg_rsp, z_cfg_rsp, n_host_rsp, z_host_rsp;
    logic v_busy, v_done, v_err, n_busy, n_done, n_err, z_busy, z_done, z_err;

    hyperbus_cfg_init #(
        .NumEntries(3), .InitAddr(TabAddr), .InitData(TabData),
        .VerifyEn(1'b1), .MaxRetries(3), .StartDelay(16)
    ) u_v (
        .clk_i(clk), .rst_ni(rst_v_n), .host_req_i(v_host_req), .host_rsp_o(v_host_rsp),
        .cfg_req_o(v_cfg_req), .cfg_rsp_i(v_cfg_rsp),
        .busy_o(v_busy), .init_done_o(v_done), .init_error_o(v_err)
    );

    hyperbus_cfg_init #(
        .NumEntries(3), .InitAddr(TabAddr), .InitData(TabData),
        .VerifyEn(1'b0), .MaxRetries(3), .StartDelay(16)
    ) u_n (
        .clk_i(clk), .rst_ni(rst_o_n), .host_req_i(n_host_req), .host_rsp_o(n_host_rsp),
        .cfg_req_o(n_cfg_req), .cfg_rsp_i(n_cfg_rsp),
        .busy_o(n_busy), .init_done_o(n_done), .init_error_o(n_err)
    );

    hyperbus_cfg_init #(
        .NumEntries(0), .VerifyEn(1'b1), .MaxRetries(3), .StartDelay(16)
    ) u_z (
        .clk_i(clk), .rst_ni(rst_o_n), .host_req_i(z_host_req), .host_rsp_o(z_host_rsp),
        .cfg_req_o(z_cfg_req), .cfg_rsp_i(z_cfg_rsp),
        .busy_o(z_busy), .init_done_o(z_done), .init_error_o(z_err)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic acc_t mk_acc(input logic w, input logic [31:0] a, input logic [31:0] d);
        acc_t r;
        r.write = w;
        r.addr  = a;
        r.wdata = w ? d : 32'h0;
        r.wstrb = w ? 4'hF : 4'h0;
        return r;
    endfunction

    function automatic acc_t obs_acc(input hyper_reg_req_t q);
        return mk_acc(q.write, q.addr, q.wdata);
    endfunction

    // Slave for u_v: stores writes, optional corruption of entry-1 reads, programmable ready delay.
    logic [31:0] mem_v [16];
    bit   [15:0] wr_v = '0;
    logic [3:0]  v_widx;
    int          v_wait = 0;
    int          v_target = 0;
    bit          v_rand, v_corrupt;
    int          v_fixed;

    assign v_widx = v_cfg_req.addr[5:2];

    always_comb begin
        v_cfg_rsp       = '0;
        v_cfg_rsp.ready = v_cfg_req.valid && (v_wait >= v_target);
        v_cfg_rsp.rdata = wr_v[v_widx] ? mem_v[v_widx] : ~v_cfg_req.addr;
        if (v_corrupt && (v_cfg_req.addr == 32'h4)) begin
            v_cfg_rsp.rdata = v_cfg_rsp.rdata ^ 32'h1;
        end
    end

    always @(posedge clk) begin
        if (v_cfg_req.valid && v_cfg_rsp.ready && v_cfg_req.write) begin
            mem_v[v_widx] <= v_cfg_req.wdata;
            wr_v[v_widx]  <= 1'b1;
        end
        if (v_cfg_req.valid && !v_cfg_rsp.ready) begin
            v_wait <= v_wait + 1;
        end else begin
            v_wait   <= 0;
            v_target <= v_rand ? int'($urandom_range(5, 0)) : v_fixed;
        end
    end

    always_comb begin
        n_cfg_rsp       = '0;
        n_cfg_rsp.ready = n_cfg_req.valid;
        z_cfg_rsp       = '0;
        z_cfg_rsp.ready = z_cfg_req.valid;
    end

    acc_t exp_v[$];
    acc_t exp_n[$];
    bit   stab_en = 1'b0;
    bit   v_prev_pend = 1'b0;
    hyper_reg_req_t v_prev_req = '0;
    bit   z_valid_seen = 1'b0;

    always @(negedge clk) begin
        if (v_busy && v_cfg_req.valid && v_cfg_rsp.ready) begin
            check("v_expected_access", 128'(exp_v.size() > 0), 128'(1'b1));
            if (exp_v.size() > 0) begin
                check("v_access", 128'(obs_acc(v_cfg_req)), 128'(exp_v.pop_front()));
            end
        end
        if (stab_en && v_prev_pend && v_busy) begin
            check("v_req_stable", 128'(v_cfg_req), 128'(v_prev_req));
        end
        if (v_busy) begin
            check("v_host_stalled", 128'(v_host_rsp), 128'(0));
        end
        v_prev_pend <= v_cfg_req.valid && !v_cfg_rsp.ready;
        v_prev_req  <= v_cfg_req;
        if (n_busy && n_cfg_req.valid && n_cfg_rsp.ready) begin
            check("n_expected_access", 128'(exp_n.size() > 0), 128'(1'b1));
            if (exp_n.size() > 0) begin
                check("n_access", 128'(obs_acc(n_cfg_req)), 128'(exp_n.pop_front()));
            end
        end
        if (z_busy && z_cfg_req.valid) begin
            z_valid_seen <= 1'b1;
        end
    end

    task automatic push_v_clean();
        for (int i = 0; i < 3; i++) begin
            exp_v.push_back(mk_acc(1'b1, TabAddr[i], TabData[i]));
            exp_v.push_back(mk_acc(1'b0, TabAddr[i], 32'h0));
        end
    endtask

    initial begin
        int n_first, n_done_at, z_done_at, v_done_at, first_v;
        bit host_checked, drop_host, found;

        rst_v_n    = 1'b0;
        rst_o_n    = 1'b0;
        v_host_req = '0;
        n_host_req = '0;
        z_host_req = '0;
        v_corrupt  = 1'b1;
        v_rand     = 1'b0;
        v_fixed    = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_v_cfg_req", 128'(v_cfg_req), 128'(0));
        check("rst_v_host_rsp", 128'(v_host_rsp), 128'(0));
        check("rst_v_busy", 128'(v_busy), 128'(1'b1));
        check("rst_v_done", 128'(v_done), 128'(1'b0));
        check("rst_v_err", 128'(v_err), 128'(1'b0));
        check("rst_n_busy", 128'(n_busy), 128'(1'b1));
        check("rst_z_done", 128'(z_done), 128'(1'b0));

        // Run 1: entry 1 always reads back corrupted on u_v; u_n writes only; u_z empty table.
        exp_v.push_back(mk_acc(1'b1, TabAddr[0], TabData[0]));
        exp_v.push_back(mk_acc(1'b0, TabAddr[0], 32'h0));
        for (int a = 0; a < 4; a++) begin
            exp_v.push_back(mk_acc(1'b1, TabAddr[1], TabData[1]));
            exp_v.push_back(mk_acc(1'b0, TabAddr[1], 32'h0));
        end
        exp_v.push_back(mk_acc(1'b1, TabAddr[2], TabData[2]));
        exp_v.push_back(mk_acc(1'b0, TabAddr[2], 32'h0));
        for (int i = 0; i < 3; i++) exp_n.push_back(mk_acc(1'b1, TabAddr[i], TabData[i]));

        n_first = -1; n_done_at = -1; z_done_at = -1; v_done_at = -1;
        host_checked = 1'b0; drop_host = 1'b0;
        @(negedge clk);
        rst_v_n = 1'b1;
        rst_o_n = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (drop_host) begin
                v_host_req = '0;
                drop_host  = 1'b0;
            end
            if (k == 2) begin
                v_host_req.valid = 1'b1;
                v_host_req.write = 1'b0;
                v_host_req.addr  = 32'h10;
            end
            if (n_first < 0 && n_cfg_req.valid) n_first = k;
            if (n_done_at < 0 && n_done) n_done_at = k;
            if (z_done_at < 0 && z_done) z_done_at = k;
            if (v_done_at < 0 && v_done) begin
                v_done_at = k;
                check("host_pass_ready", 128'(v_host_rsp.ready), 128'(1'b1));
                check("host_pass_rdata", 128'(v_host_rsp.rdata), 128'(HostRdExp));
                check("host_pass_addr", 128'(v_cfg_req.addr), 128'(32'h10));
                host_checked = 1'b1;
                drop_host    = 1'b1;
            end
        end
        check("n_first_valid_cycle", 128'(n_first), 128'(16));
        check("n_done_cycle", 128'(n_done_at), 128'(21));
        check("n_error", 128'(n_err), 128'(1'b0));
        check("n_queue_drained", 128'(exp_n.size()), 128'(0));
        check("z_done_cycle", 128'(z_done_at), 128'(16));
        check("z_never_valid", 128'(z_valid_seen), 128'(1'b0));
        check("v_done_cycle", 128'(v_done_at), 128'(39));
        check("v_error_sticky", 128'(v_err), 128'(1'b1));
        check("v_done_sticky", 128'(v_done), 128'(1'b1));
        check("v_queue_drained", 128'(exp_v.size()), 128'(0));
        check("host_completed", 128'(host_checked), 128'(1'b1));

        // Run 2: clean data, random 0-5 cycle ready delay; sticky error must clear on reset.
        @(negedge clk);
        rst_v_n   = 1'b0;
        v_corrupt = 1'b0;
        v_rand    = 1'b1;
        push_v_clean();
        @(negedge clk);
        check("rst_clears_error", 128'(v_err), 128'(1'b0));
        rst_v_n = 1'b1;
        stab_en = 1'b1;
        for (int k = 0; k < 300 && !v_done; k++) @(posedge clk);
        #1;
        check("rand_done_in_time", 128'(v_done), 128'(1'b1));
        check("rand_error", 128'(v_err), 128'(1'b0));
        check("rand_queue_drained", 128'(exp_v.size()), 128'(0));
        stab_en = 1'b0;

        // Run 3: reset while the verify read of entry 1 is waiting for ready.
        @(negedge clk);
        rst_v_n = 1'b0;
        v_rand  = 1'b0;
        v_fixed = 3;
        push_v_clean();
        @(negedge clk);
        rst_v_n = 1'b1;
        found   = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (v_cfg_req.valid && !v_cfg_req.write && v_cfg_req.addr == 32'h4 && !v_cfg_rsp.ready) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_verify_reached", 128'(found), 128'(1'b1));
        exp_v.delete();
        rst_v_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_cfg_req", 128'(v_cfg_req), 128'(0));
        check("midrst_busy", 128'(v_busy), 128'(1'b1));
        check("midrst_done", 128'(v_done), 128'(1'b0));
        push_v_clean();
        @(negedge clk);
        rst_v_n = 1'b1;
        first_v = -1;
        for (int k = 1; k <= 200 && !v_done; k++) begin
            @(posedge clk);
            #1;
            if (first_v < 0 && v_cfg_req.valid) first_v = k;
        end
        check("restart_first_valid", 128'(first_v), 128'(16));
        check("restart_done", 128'(v_done), 128'(1'b1));
        check("restart_error", 128'(v_err), 128'(1'b0));
        check("restart_queue_drained", 128'(exp_v.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
